// File: rtl/text_buf_pkg.sv
// Shared types and helpers for the text buffer: control characters, clear-engine
// states and the logical-to-physical row mapping.
package text_buf_pkg;

    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_NUL = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ALL = 2'd1,
        CLR_ROW = 2'd2
    } state_t;

    // Row counts are powers of two, so the modulo reduces to a mask.
    function automatic logic [31:0] phys_row(input logic [31:0] log_row,
                                             input logic [31:0] base,
                                             input logic [31:0] num_rows);
        return (log_row + base) & (num_rows - 32'd1);
    endfunction

    function automatic logic is_ctrl_char(input logic [7:0] c);
        return (c == CHAR_CR) || (c == CHAR_LF);
    endfunction

endpackage

// File: rtl/text_buffer_ram_if.sv
// Writer/reader bus of the text buffer: control pulses, write port, read port,
// tap outputs and status.
interface text_buffer_ram_if #(
    parameter int ROWS     = 32,
    parameter int COLS     = 4,
    parameter int DATA_W   = 8,
    parameter int NUM_TAPS = 2
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    logic                       clear;
    logic                       scroll;
    logic                       we;
    logic [ROW_W-1:0]           w_row;
    logic [COL_W-1:0]           w_col;
    logic [DATA_W-1:0]          din;
    logic [ROW_W-1:0]           r_row;
    logic [COL_W-1:0]           r_col;
    logic [DATA_W-1:0]          dout;
    logic [NUM_TAPS*DATA_W-1:0] tap_dout;
    logic                       busy;
    logic [ROW_W-1:0]           base_row;

    modport master (
        output clear, scroll, we, w_row, w_col, din, r_row, r_col,
        input  dout, tap_dout, busy, base_row
    );

    modport slave (
        input  clear, scroll, we, w_row, w_col, din, r_row, r_col,
        output dout, tap_dout, busy, base_row
    );

endinterface

// File: rtl/text_buf_clear_fsm.sv
// Clear engine: owns the circular row base and sequences zero-writes for the
// full-buffer wipe and the single recycled-row clear.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no clear in progress, user writes accepted
//   CLR_ALL | zeroing every cell, one per cycle, cnt = linear cell index
//   CLR_ROW | zeroing row r_clear_row after a scroll, cnt = column
module text_buf_clear_fsm
    import text_buf_pkg::*;
#(
    parameter int ROWS = 32,
    parameter int COLS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_clear,
    input  logic                     i_scroll,
    output logic                     o_busy,
    output logic [$clog2(ROWS)-1:0]  o_base_row,
    output logic                     o_clr_we,
    output logic [$clog2(ROWS)-1:0]  o_clr_row,
    output logic [$clog2(COLS)-1:0]  o_clr_col
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int CNT_W = ROW_W + COL_W;
    localparam logic [CNT_W-1:0] CNT_ALL_LAST = CNT_W'(ROWS * COLS - 1);
    localparam logic [CNT_W-1:0] CNT_ROW_LAST = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE      = ROW_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [ROW_W-1:0] r_base_row;
    logic [ROW_W-1:0] w_base_nxt;
    logic [ROW_W-1:0] r_clear_row;
    logic [ROW_W-1:0] w_clear_row_nxt;

    // Reset lands in CLR_ALL so the unreset array is wiped before first use.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= CLR_ALL;
            r_cnt       <= '0;
            r_base_row  <= '0;
            r_clear_row <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_base_row  <= w_base_nxt;
            r_clear_row <= w_clear_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_base_nxt      = r_base_row;
        w_clear_row_nxt = r_clear_row;
        case (r_state)
            IDLE: begin
                if (i_clear) begin
                    w_state_nxt = CLR_ALL;
                    w_cnt_nxt   = '0;
                end else if (i_scroll) begin
                    w_state_nxt     = CLR_ROW;
                    w_cnt_nxt       = '0;
                    w_base_nxt      = r_base_row + ROW_ONE;
                    w_clear_row_nxt = r_base_row;
                end
            end
            CLR_ALL: begin
                if (i_clear) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_ALL_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            CLR_ROW: begin
                // A clear abandons the row wipe; the advanced base is kept.
                if (i_clear) begin
                    w_state_nxt = CLR_ALL;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_ROW_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        o_busy    = (r_state != IDLE);
        o_clr_we  = (r_state != IDLE);
        o_clr_row = r_cnt[CNT_W-1 -: ROW_W];
        o_clr_col = r_cnt[COL_W-1:0];
        if (r_state == CLR_ROW) begin
            o_clr_row = r_clear_row;
        end
    end

    assign o_base_row = r_base_row;

endmodule

// File: rtl/text_buffer_ram.sv
// Two-port rows x columns character buffer with circular row base, clear
// engine, control-character filter and registered logical-row-0 taps.
module text_buffer_ram
    import text_buf_pkg::*;
#(
    parameter int ROWS        = 32,
    parameter int COLS        = 4,
    parameter int DATA_W      = 8,
    parameter int NUM_TAPS    = 2,
    parameter int FILTER_CTRL = 1
) (
    input logic               clk,
    input logic               reset_n,
    text_buffer_ram_if.slave  bus
);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int ADDR_W = ROW_W + COL_W;
    localparam int DEPTH  = ROWS * COLS;

    logic [DATA_W-1:0]          r_mem [DEPTH];
    logic [DATA_W-1:0]          r_dout;
    logic [NUM_TAPS*DATA_W-1:0] r_tap;

    logic              w_busy;
    logic [ROW_W-1:0]  w_base_row;
    logic              w_clr_we;
    logic [ROW_W-1:0]  w_clr_row;
    logic [COL_W-1:0]  w_clr_col;
    logic [ROW_W-1:0]  w_wr_row_phys;
    logic [ROW_W-1:0]  w_rd_row_phys;
    logic [7:0]        w_din_lo;
    logic              w_filtered;
    logic              w_wr_ok;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [ADDR_W-1:0] w_rd_addr;

    text_buf_clear_fsm #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_clear_fsm (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (bus.clear),
        .i_scroll   (bus.scroll),
        .o_busy     (w_busy),
        .o_base_row (w_base_row),
        .o_clr_we   (w_clr_we),
        .o_clr_row  (w_clr_row),
        .o_clr_col  (w_clr_col)
    );

    assign w_wr_row_phys = ROW_W'(phys_row(32'(bus.w_row), 32'(w_base_row), 32'(ROWS)));
    assign w_rd_row_phys = ROW_W'(phys_row(32'(bus.r_row), 32'(w_base_row), 32'(ROWS)));
    assign w_din_lo      = 8'(bus.din);
    assign w_filtered    = (FILTER_CTRL != 0) && is_ctrl_char(w_din_lo);
    // In IDLE any clear/scroll is taken, so a write beside one is dropped.
    assign w_wr_ok       = bus.we && !w_busy && !w_filtered && !bus.clear && !bus.scroll;
    assign w_rd_addr     = {w_rd_row_phys, bus.r_col};

    always_comb begin
        w_mem_we   = w_clr_we || w_wr_ok;
        w_mem_addr = {w_wr_row_phys, bus.w_col};
        w_mem_data = bus.din;
        if (w_clr_we) begin
            w_mem_addr = {w_clr_row, w_clr_col};
            w_mem_data = DATA_W'(CHAR_NUL);
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Non-blocking reads of r_mem give read-first behaviour on address collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout <= '0;
            r_tap  <= '0;
        end else begin
            r_dout <= r_mem[w_rd_addr];
            for (int t = 0; t < NUM_TAPS; t++) begin
                r_tap[t*DATA_W +: DATA_W] <= r_mem[{w_base_row, COL_W'(t)}];
            end
        end
    end

    assign bus.dout     = r_dout;
    assign bus.tap_dout = r_tap;
    assign bus.busy     = w_busy;
    assign bus.base_row = w_base_row;

endmodule

// File: tb/tb_text_buffer_ram.sv
// Self-checking bench for text_buffer_ram: vector table plus hand sequences for
// wipe timing, scrolling, clear/scroll interaction and async reset.
module tb_text_buffer_ram;
    localparam int ROWS = 32;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int NT   = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    text_buffer_ram_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .NUM_TAPS(NT)) bus ();
    text_buffer_ram_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .NUM_TAPS(NT)) bus2 ();

    text_buffer_ram #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .NUM_TAPS(NT), .FILTER_CTRL(1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    text_buffer_ram #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .NUM_TAPS(NT), .FILTER_CTRL(0)) dut_nf (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] m_mem [ROWS*COLS];
    int         m_base = 0;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bit         wr;
        int         row;
        int         col;
        logic [7:0] d;
        logic [7:0] exp;
        string      name;
    } vec_t;
    vec_t vecs[13];

    function automatic int m_idx(int row, int col);
        return ((row + m_base) % ROWS) * COLS + col;
    endfunction

    function automatic logic [7:0] m_get(int row, int col);
        return m_mem[m_idx(row, col)];
    endfunction

    function automatic void m_clear_all();
        for (int i = 0; i < ROWS*COLS; i++) m_mem[i] = 8'h00;
    endfunction

    function automatic void m_scroll();
        for (int c = 0; c < COLS; c++) m_mem[m_base*COLS + c] = 8'h00;
        m_base = (m_base + 1) % ROWS;
    endfunction

    function automatic void m_write(int row, int col, logic [7:0] d);
        if (d != 8'h0D && d != 8'h0A) m_mem[m_idx(row, col)] = d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int row, input int col, input logic [7:0] d);
        bus.we    = 1'b1;
        bus.w_row = 5'(row);
        bus.w_col = 2'(col);
        bus.din   = d;
        cyc();
        bus.we    = 1'b0;
    endtask

    task automatic rd(input int row, input int col, input logic [7:0] exp, input string name);
        sb_t e;
        bus.r_row = 5'(row);
        bus.r_col = 2'(col);
        sb_q.push_back('{exp, name});
        cyc();
        e = sb_q.pop_front();
        chk(e.name, 32'(bus.dout), 32'(e.exp));
    endtask

    task automatic pulse(input bit c, input bit s);
        bus.clear  = c;
        bus.scroll = s;
        cyc();
        bus.clear  = 1'b0;
        bus.scroll = 1'b0;
    endtask

    task automatic wait_busy(input int exp_n, input string name);
        int n = 0;
        while (bus.busy && n < 1000) begin
            cyc();
            n++;
        end
        chk(name, 32'(n), 32'(exp_n));
    endtask

    initial begin
        sb_t e;
        bus.clear = 0; bus.scroll = 0; bus.we = 0; bus.w_row = 0; bus.w_col = 0;
        bus.din = 0; bus.r_row = 0; bus.r_col = 0;
        bus2.clear = 0; bus2.scroll = 0; bus2.we = 0; bus2.w_row = 0; bus2.w_col = 0;
        bus2.din = 0; bus2.r_row = 0; bus2.r_col = 0;
        m_clear_all();

        vecs[0]  = '{1'b1,  3, 2, 8'h41, 8'h00, "wr_3_2"};
        vecs[1]  = '{1'b0,  3, 2, 8'h00, 8'h41, "rd_3_2"};
        vecs[2]  = '{1'b1,  3, 2, 8'h0D, 8'h00, "wr_cr"};
        vecs[3]  = '{1'b0,  3, 2, 8'h00, 8'h41, "cr_filtered"};
        vecs[4]  = '{1'b1,  3, 2, 8'h0A, 8'h00, "wr_lf"};
        vecs[5]  = '{1'b0,  3, 2, 8'h00, 8'h41, "lf_filtered"};
        vecs[6]  = '{1'b1, 31, 3, 8'hFF, 8'h00, "wr_31_3"};
        vecs[7]  = '{1'b0, 31, 3, 8'h00, 8'hFF, "rd_31_3"};
        vecs[8]  = '{1'b1,  0, 0, 8'h0E, 8'h00, "wr_0_0"};
        vecs[9]  = '{1'b0,  0, 0, 8'h00, 8'h0E, "rd_0_0"};
        vecs[10] = '{1'b0,  5, 1, 8'h00, 8'h00, "rd_untouched"};
        vecs[11] = '{1'b1,  3, 2, 8'h42, 8'h00, "wr_3_2_b"};
        vecs[12] = '{1'b0,  3, 2, 8'h00, 8'h42, "rd_3_2_b"};

        // Reset state, then the power-up wipe.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(bus.dout), 32'h0);
        chk("rst_tap", 32'(bus.tap_dout), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h1);
        chk("rst_base", 32'(bus.base_row), 32'h0);
        reset_n = 1'b1;
        wait_busy(ROWS*COLS, "boot_busy");
        chk("boot_base", 32'(bus.base_row), 32'h0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                rd(r, c, 8'h00, "boot_zero");

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) begin
                wr(vecs[i].row, vecs[i].col, vecs[i].d);
                m_write(vecs[i].row, vecs[i].col, vecs[i].d);
            end else begin
                rd(vecs[i].row, vecs[i].col, vecs[i].exp, vecs[i].name);
            end
        end

        // Same-cycle write and read of one cell returns the old value.
        bus.we = 1'b1; bus.w_row = 5'd3; bus.w_col = 2'd2; bus.din = 8'h55;
        bus.r_row = 5'd3; bus.r_col = 2'd2;
        sb_q.push_back('{m_get(3, 2), "read_first"});
        cyc();
        bus.we = 1'b0;
        m_write(3, 2, 8'h55);
        e = sb_q.pop_front();
        chk(e.name, 32'(bus.dout), 32'(e.exp));
        rd(3, 2, 8'h55, "after_read_first");

        // Unfiltered instance stores control characters.
        bus2.we = 1'b1; bus2.w_row = 5'd3; bus2.w_col = 2'd2; bus2.din = 8'h0D;
        cyc();
        bus2.w_col = 2'd1; bus2.din = 8'h0A;
        cyc();
        bus2.we = 1'b0; bus2.r_row = 5'd3; bus2.r_col = 2'd2;
        cyc();
        chk("nofilter_cr", 32'(bus2.dout), 32'h0D);
        bus2.r_col = 2'd1;
        cyc();
        chk("nofilter_lf", 32'(bus2.dout), 32'h0A);

        // One-row scroll.
        for (int c = 0; c < COLS; c++) begin
            wr(0, c, 8'(8'h41 + c)); m_write(0, c, 8'(8'h41 + c));
            wr(1, c, 8'(8'h45 + c)); m_write(1, c, 8'(8'h45 + c));
        end
        pulse(1'b0, 1'b1);
        m_scroll();
        chk("scroll_base", 32'(bus.base_row), 32'h1);
        wait_busy(COLS, "scroll_busy");
        for (int c = 0; c < COLS; c++) rd(0, c, 8'(8'h45 + c), "scroll_row0");
        for (int c = 0; c < COLS; c++) rd(31, c, 8'h00, "scroll_row31");
        chk("scroll_tap", 32'(bus.tap_dout), 32'h4645);

        // Base wraps after a full revolution.
        for (int i = 1; i < ROWS; i++) begin
            pulse(1'b0, 1'b1);
            m_scroll();
            chk("scroll_n_base", 32'(bus.base_row), 32'(m_base));
            wait_busy(COLS, "scroll_n_busy");
        end
        chk("wrap_base", 32'(bus.base_row), 32'h0);
        wr(2, 1, 8'h33); m_write(2, 1, 8'h33);
        wr(0, 0, 8'h21); m_write(0, 0, 8'h21);
        wr(0, 1, 8'h22); m_write(0, 1, 8'h22);
        rd(2, 1, m_get(2, 1), "wrap_rd");
        rd(7, 3, m_get(7, 3), "wrap_rd_zero");
        chk("wrap_tap", 32'(bus.tap_dout), 32'({m_get(0, 1), m_get(0, 0)}));

        // Clear beats scroll in the same cycle.
        pulse(1'b1, 1'b1);
        chk("cs_base", 32'(bus.base_row), 32'(m_base));
        wait_busy(ROWS*COLS, "cs_busy");
        m_clear_all();
        rd(2, 1, 8'h00, "cs_wiped");

        // Clear on the second cycle of a row clear.
        wr(7, 0, 8'h77); m_write(7, 0, 8'h77);
        bus.scroll = 1'b1;
        cyc();
        bus.scroll = 1'b0;
        m_scroll();
        cyc();
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        wait_busy(ROWS*COLS, "abort_busy");
        m_clear_all();
        chk("abort_base", 32'(bus.base_row), 32'(m_base));
        rd(6, 0, 8'h00, "abort_wiped");

        // Writes and scrolls while busy are ignored.
        wr(10, 1, 8'h22); m_write(10, 1, 8'h22);
        pulse(1'b0, 1'b1);
        m_scroll();
        wr(9, 1, 8'h99);
        pulse(1'b0, 1'b1);
        chk("busy_scroll_base", 32'(bus.base_row), 32'(m_base));
        wait_busy(2, "busy_remaining");
        rd(9, 1, m_get(9, 1), "busy_write_ignored");
        chk("busy_write_val", 32'(m_get(9, 1)), 32'h22);

        // Async reset in the middle of a wipe.
        wr(20, 3, 8'h5A); m_write(20, 3, 8'h5A);
        rd(20, 3, 8'h5A, "pre_reset_dout");
        pulse(1'b1, 1'b0);
        repeat (10) cyc();
        chk("mid_clear_dout", 32'(bus.dout), 32'h5A);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_dout", 32'(bus.dout), 32'h0);
        chk("async_busy", 32'(bus.busy), 32'h1);
        chk("async_base", 32'(bus.base_row), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_clear_all();
        m_base = 0;
        wait_busy(ROWS*COLS, "rewipe_busy");
        rd(20, 3, 8'h00, "rewiped");
        chk("rewipe_tap", 32'(bus.tap_dout), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/text_buffer_ram.md
Name: text_buffer_ram

Overview:
Parametrised two-port character buffer (rows x columns of DATA_W-bit cells) between the keyboard/UART writer and the display reader. Successor to the fixed 32x4 buffer, adding:
- a per-cell clear engine with a busy flag;
- automatic wipe after reset;
- a circular row base for one-row scrolling with clear of the recycled row;
- configurable control-character filtering and N row-0 tap outputs.

Parameters:
ROWS, 32, number of rows (power of two, >=2)
COLS, 4, cells per row (power of two, >=2)
DATA_W, 8, cell width in bits
NUM_TAPS, 2, direct outputs of logical row 0, columns 0..NUM_TAPS-1 (1..COLS)
FILTER_CTRL, 1, 1 = drop writes of 8'h0D and 8'h0A (compare low 8 bits)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  sync pulse: wipe entire buffer
scroll  in  1  sync pulse: scroll up one row
we  in  1  write enable
w_row  in  $clog2(ROWS)  logical write row
w_col  in  $clog2(COLS)  write column
din  in  DATA_W  write data
r_row  in  $clog2(ROWS)  logical read row
r_col  in  $clog2(COLS)  read column
dout  out  DATA_W  registered read data
tap_dout  out  NUM_TAPS*DATA_W  registered logical row 0 cells; tap t at bits [t*DATA_W +: DATA_W]
busy  out  1  clear engine active; writes ignored
base_row  out  $clog2(ROWS)  physical row currently mapped to logical row 0

Behaviour:
- Address map: physical row = (logical row + base_row) mod ROWS; wraps naturally by width.
- reset_n low (async):
  - state=CLR_ALL, cnt=0, base_row=0, busy=1, dout=0, tap_dout=0.
  - Memory array is not reset.
  - After release, the wipe runs from the first clk edge.
- States:
  - IDLE:
    - clear -> CLR_ALL, cnt=0.
    - Else scroll -> CLR_ROW, cnt=0, base_row<=base_row+1, clear_row<=old base_row.
  - CLR_ALL:
    - Each cycle writes 0 to cell cnt (row=cnt/COLS, col=cnt%COLS, physical).
    - cnt==ROWS*COLS-1 -> IDLE.
    - Duration exactly ROWS*COLS cycles.
  - CLR_ROW:
    - Writes 0 to (clear_row, cnt).
    - cnt==COLS-1 -> IDLE.
    - Duration exactly COLS cycles.
- busy = (state != IDLE), combinational from the state register.
- Simultaneous events:
  - clear and scroll in the same IDLE cycle: clear wins, scroll dropped.
  - scroll while busy: dropped, not queued.
  - clear during CLR_ROW: aborts the row clear, enters CLR_ALL at cnt=0; base_row keeps its new value.
  - clear during CLR_ALL: restarts at cnt=0.
- Writes:
  - Accepted only when we=1, busy=0 and not (FILTER_CTRL and din is 0x0D/0x0A).
  - A write in the same cycle as an accepted clear/scroll is dropped.
  - The write address uses base_row before that edge's update.
- Reads:
  - 1-cycle latency; dout at edge N+1 = cell addressed at edge N using base_row at edge N.
  - Read-first: a same-address write in the same cycle returns old data.
  - Reads are permitted while busy and return current (possibly partly cleared) contents.
- tap_dout: registered every cycle from logical row 0, columns 0..NUM_TAPS-1; same latency and base rule as dout.

Decomposition:
- Shared package text_buf_pkg:
  - CHAR_CR=8'h0D, CHAR_LF=8'h0A, CHAR_NUL=8'h00;
  - state typedef {IDLE, CLR_ALL, CLR_ROW};
  - helper function for the physical row.
- One sub-module, text_buf_clear_fsm: state, cnt, clear_row, base_row, busy; outputs clear-write enable and address.
- Top level holds the memory array, write mux (clear engine has priority) and read/tap registers.

Test Plan:
- Release reset_n at t0 -> busy=1 for exactly 128 cycles (defaults), then 0; every cell reads 0; base_row=0.
- Write 0x41 to (3,2) idle, read (3,2) next cycle -> dout=0x41 one cycle after address. Write 0x0D to (3,2) -> read still 0x41. With FILTER_CTRL=0 -> 0x0D stored.
- Fill row 0 with 0x41,0x42,0x43,0x44, row 1 with 0x45..0x48, pulse scroll:
  - base_row=1; busy=1 for exactly 4 cycles;
  - logical row 0 reads 0x45..0x48; logical row 31 reads all 0;
  - tap_dout = {0x46,0x45}.
- Scroll 32 times -> base_row wraps 31->0; writes and reads remain coherent after wrap.
- Assert clear and scroll in the same cycle -> base_row unchanged, busy for 128 cycles. Clear at cycle 2 of CLR_ROW -> full 128-cycle wipe, base_row keeps its increment.
- Write with we=1 during busy -> cell unchanged. Pulse reset_n low mid-CLR_ALL -> outputs 0 immediately (async), wipe restarts at cnt=0 after release.
